register_file_16x32: RTL and testbench
======================================

# register_file_16x32

Sixteen-entry, 32-bit general-purpose register file for the simple 32-bit processor. It sits directly downstream of `decoder_4to16`: the decoder's 16-bit one-hot `enable` vector drives the write-select port, and each bit selects one register row. Two synchronous read ports feed the ALU operand stage. A sticky error flag reports any write whose select vector is not one-hot.

## Interface

Parameters:
- `WIDTH`, 32: data width of each register.
- `DEPTH`, 16: number of registers; fixed to match the decoder's 16 outputs.
- `ADDR_W`, 4: read-address width; equals log2(`DEPTH`).

Ports:
- `clk`, input, 1: single clock; rising-edge active.
- `reset`, input, 1: asynchronous, active-high reset.
- `wr_en`, input, 1: write request for this cycle.
- `wr_sel`, input, 16: one-hot row select, driven by the `decoder_4to16` `enable` output.
- `wr_data`, input, `WIDTH`: write data.
- `rd_en`, input, 1: read request; samples both read addresses.
- `rd_addr_a`, input, `ADDR_W`: read port A address.
- `rd_addr_b`, input, `ADDR_W`: read port B address.
- `rd_data_a`, output, `WIDTH`: registered read data for port A.
- `rd_data_b`, output, `WIDTH`: registered read data for port B.
- `rd_valid`, output, 1: high for exactly one cycle when `rd_data_a`/`rd_data_b` carry new results.
- `sel_error`, output, 1: sticky flag for a write attempted with an illegal `wr_sel`.

## Operation

- **Register 0 is hardwired to zero.** Writes to it (`wr_sel == 16'h0001`) are silently dropped; they are legal and do not set `sel_error`. Reads of r0 always return 0.
- **Write.** At a rising edge with `wr_en = 1` and `wr_sel` exactly one-hot at bit k (k ≥ 1), row k takes `wr_data`.
- **Illegal select.** With `wr_en = 1` and `wr_sel` zero, multi-hot, or containing X/Z:
  - No row is written.
  - `sel_error` is set to 1 and holds until `reset`.
  - With `wr_en = 0`, `wr_sel` is ignored completely and may be any value.
- **Read.**
  - At a rising edge with `rd_en = 1`, both addresses are sampled. `rd_data_a`/`rd_data_b` update at that edge, and `rd_valid` goes to 1 for one cycle.
  - With `rd_en = 0`, the data outputs hold their last values and `rd_valid` is 0.
- **Write-first bypass.** If a legal write to row k and a read of address k (k ≠ 0) fall on the same edge, the read returns the new `wr_data`. This applies independently to each port.
- **Same-address reads.** When both ports read the same address, both return the same value.
- **Reset (asynchronous, any time, including mid-read or mid-write).**
  - All rows are cleared to 0.
  - `rd_data_a` = 0, `rd_data_b` = 0, `rd_valid` = 0, `sel_error` = 0.
  - A write or read coinciding with reset assertion is discarded.

## Timing

- Write latency is one edge: data written at edge N is readable by a read sampled at edge N (via the bypass) or at any later edge.
- Read latency is one cycle: `rd_en` high before edge N produces data and `rd_valid` valid after edge N.
- Back-to-back reads are supported at one per cycle. `rd_valid` stays high continuously while `rd_en` stays high.
- `sel_error` rises after the edge that sampled the illegal write.
- Every output is driven from a flop. There are no combinational paths from inputs to outputs.
- After reset deasserts, the first edge is fully functional.

## Structure

- Shared package `regfile_pkg`:
  - `WIDTH`, `DEPTH`, `ADDR_W` constants.
  - A `reg_word_t` typedef for a `WIDTH`-bit word.
  - `ZERO_REG` = 0.
- One sub-module, `onehot_to_index`:
  - Inputs: 16-bit select.
  - Outputs: 4-bit index and a `legal` flag. `legal` is 1 only when exactly one bit is set and there are no X/Z bits.
  - This is the inverse of `decoder_4to16` and is used for both the write decode and the bypass compare.
- The top level holds the register array, the read pipeline flops, and the sticky error flop.

## Test plan

1. **Reset.** Drive `reset = 1`, then release it, then read r0..r15 on both ports. Expect all data to be 0, `rd_valid` to pulse once per read, and `sel_error = 0`.
2. **Decoder-driven write sweep.** Feed `decoder_4to16` inputs 1..15 with `wr_data = 32'hA5A5_0000 + in`, then read back every row. Expect row k = `32'hA5A5_0000 + k`. Then write `32'hFFFF_FFFF` with `wr_sel = 16'h0001` and read r0. Expect 0 and `sel_error = 0`.
3. **Bypass.** Write `32'hDEAD_BEEF` to r5 while `rd_addr_a = 5` and `rd_addr_b = 6` on the same edge. Expect `rd_data_a = 32'hDEAD_BEEF` and `rd_data_b` = the old value of r6.
4. **Illegal select.** With `wr_en = 1`, apply `wr_sel = 16'h0000`, then `16'h0030`, then all-X. Expect no row to change, `sel_error = 1` from the first illegal edge onward, and `sel_error` to persist through subsequent legal writes.
5. **Reset mid-operation.** Hold `rd_en = 1` continuously and assert `reset` asynchronously between edges while a write to r9 is pending. Expect the outputs and r9 to read 0 immediately, and `rd_valid = 0` until the first read after release.

Source files
------------

// File: rtl/register_file_16x32_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg : shared sizing constants and types for the 16x32 register file
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   typedef logic [WIDTH-1:0] reg_word_t;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/register_file_16x32_onehot_to_index.sv
// ----------------------------------------------------------------------------
// onehot_to_index : one-hot row select to binary index, with a legality flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module onehot_to_index
   import regfile_pkg::*;
#(
   parameter int SEL_W = DEPTH,
   parameter int IDX_W = ADDR_W
) (
   input  logic [SEL_W-1:0] sel_i,
   output logic [IDX_W-1:0] index_o,
   output logic             legal_o
);

   localparam int CNT_W = $clog2(SEL_W + 1);

   logic [CNT_W-1:0] ones_cnt;

   always_comb begin
      index_o  = '0;
      ones_cnt = '0;
      legal_o  = 1'b0;
      for (int i = 0; i < SEL_W; i++) begin
         if (sel_i[i]) begin
            index_o  = i[IDX_W-1:0];
            ones_cnt = ones_cnt + CNT_W'(1);
         end
      end
      // An X/Z bit makes the parity unknown, so both compares fail and legal stays 0.
      if (((^sel_i) == 1'b0) || ((^sel_i) == 1'b1)) begin
         legal_o = (ones_cnt == CNT_W'(1));
      end
   end

endmodule

`default_nettype wire

// File: rtl/register_file_16x32.sv
// ----------------------------------------------------------------------------
// register_file_16x32 : 16 x 32-bit register file, one-hot write, two read ports
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_file_16x32
   import regfile_pkg::*;
#(
   parameter int WIDTH  = regfile_pkg::WIDTH,
   parameter int DEPTH  = regfile_pkg::DEPTH,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DEPTH-1:0]  wr_sel,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              rd_valid,
   output logic              sel_error
);

   logic [WIDTH-1:0]  rf_q [DEPTH];
   logic [WIDTH-1:0]  rd_a_q, rd_a_d;
   logic [WIDTH-1:0]  rd_b_q, rd_b_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] wr_idx;
   logic              wr_legal;
   logic              wr_go;

   onehot_to_index #(
      .SEL_W (DEPTH),
      .IDX_W (ADDR_W)
   ) u_wr_dec (
      .sel_i   (wr_sel),
      .index_o (wr_idx),
      .legal_o (wr_legal)
   );

   assign wr_go = wr_en & wr_legal;

   // Row 0 is only ever reset, so it collapses to a constant zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wr_go && (wr_idx != ZERO_REG)) begin
         rf_q[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      rd_a_d  = rd_a_q;
      rd_b_d  = rd_b_q;
      valid_d = rd_en;
      err_d   = err_q | (wr_en & ~wr_legal);
      if (rd_en) begin
         rd_a_d = rf_q[rd_addr_a];
         if (wr_go && (wr_idx == rd_addr_a)) begin
            rd_a_d = wr_data;
         end
         if (rd_addr_a == ZERO_REG) begin
            rd_a_d = '0;
         end
         rd_b_d = rf_q[rd_addr_b];
         if (wr_go && (wr_idx == rd_addr_b)) begin
            rd_b_d = wr_data;
         end
         if (rd_addr_b == ZERO_REG) begin
            rd_b_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rd_a_q  <= rd_a_d;
         rd_b_q  <= rd_b_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign rd_data_a = rd_a_q;
   assign rd_data_b = rd_b_q;
   assign rd_valid  = valid_q;
   assign sel_error = err_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file_16x32.sv
// ----------------------------------------------------------------------------
// tb_register_file_16x32 : scoreboard bench for the 16x32 register file
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_register_file_16x32;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [15:0] wr_sel;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        rd_valid;
   logic        sel_error;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model [16];
   logic        err_model;
   int          checks   = 0;
   int          failures = 0;

   register_file_16x32 dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .rd_valid  (rd_valid),
      .sel_error (sel_error)
   );

   always #5 clk = ~clk;

   function automatic logic sel_legal(input logic [15:0] s);
      return !$isunknown(s) && ($countones(s) == 1);
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] addr);
      if (addr == 4'd0) return 32'd0;
      if (wr_en && sel_legal(wr_sel) && wr_sel[addr]) return wr_data;
      return model[addr];
   endfunction

   function automatic exp_t pop_exp();
      if (exp_q.size() == 0) return '1;
      return exp_q.pop_front();
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) model[i] = 32'd0;
      err_model = 1'b0;
      exp_q.delete();
   endtask

   // Predict the effect of the upcoming edge, then advance past it.
   task automatic tick();
      if (rd_en) exp_q.push_back('{a: model_read(rd_addr_a), b: model_read(rd_addr_b)});
      if (wr_en) begin
         if (!sel_legal(wr_sel)) err_model = 1'b1;
         else for (int k = 1; k < 16; k++) if (wr_sel[k]) model[k] = wr_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_sel = 16'h0; wr_data = 32'h0;
      rd_en = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
   endtask

   task automatic test_reset();
      exp_t e;
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rd_valid !== 1'b0 || rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b a=%h b=%h, expected v=0 a=0 b=0", rd_valid, rd_data_a, rd_data_b);
      end
      checks++;
      if (sel_error !== 1'b0) begin
         failures++;
         $display("FAIL reset_sel_error: got %b, expected 0", sel_error);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1; rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
         tick();
         e = pop_exp();
         checks++;
         if (rd_valid !== 1'b1 || rd_data_a !== e.a || rd_data_b !== e.b) begin
            failures++;
            $display("FAIL reset_read r%0d: got v=%b a=%h b=%h, expected v=1 a=%h b=%h", i, rd_valid, rd_data_a, rd_data_b, e.a, e.b);
         end
      end
      idle();
      tick();
      checks++;
      if (rd_valid !== 1'b0 || sel_error !== err_model) begin
         failures++;
         $display("FAIL reset_idle: got v=%b err=%b, expected v=0 err=%b", rd_valid, sel_error, err_model);
      end
   endtask

   task automatic test_write_sweep();
      exp_t e;
      for (int in = 1; in < 16; in++) begin
         idle();
         wr_en = 1'b1; wr_sel = 16'(1) << in; wr_data = 32'hA5A5_0000 + 32'(in);
         tick();
      end
      for (int k = 0; k < 16; k++) begin
         idle();
         rd_en = 1'b1; rd_addr_a = 4'(k); rd_addr_b = 4'(k);
         tick();
         e = pop_exp();
         checks++;
         if (rd_valid !== 1'b1 || rd_data_a !== e.a || rd_data_b !== e.b) begin
            failures++;
            $display("FAIL sweep_read r%0d: got v=%b a=%h b=%h, expected v=1 a=%h b=%h", k, rd_valid, rd_data_a, rd_data_b, e.a, e.b);
         end
      end
      idle();
      rd_addr_a = 4'd3; rd_addr_b = 4'd4;
      tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_data_a !== e.a || rd_data_b !== e.b) begin
         failures++;
         $display("FAIL read_hold: got v=%b a=%h b=%h, expected v=0 a=%h b=%h", rd_valid, rd_data_a, rd_data_b, e.a, e.b);
      end
      idle();
      wr_en = 1'b1; wr_sel = 16'h0001; wr_data = 32'hFFFF_FFFF;
      tick();
      idle();
      rd_en = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
      tick();
      e = pop_exp();
      checks++;
      if (rd_valid !== 1'b1 || rd_data_a !== e.a || rd_data_b !== e.b || sel_error !== err_model) begin
         failures++;
         $display("FAIL r0_write: got v=%b a=%h b=%h err=%b, expected v=1 a=%h b=%h err=%b", rd_valid, rd_data_a, rd_data_b, sel_error, e.a, e.b, err_model);
      end
   endtask

   task automatic test_bypass();
      exp_t e;
      idle();
      wr_en = 1'b1; wr_sel = 16'h0020; wr_data = 32'hDEAD_BEEF;
      rd_en = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd6;
      tick();
      e = pop_exp();
      checks++;
      if (rd_data_a !== e.a || rd_data_b !== e.b || rd_valid !== 1'b1) begin
         failures++;
         $display("FAIL bypass_a: got v=%b a=%h b=%h, expected v=1 a=%h b=%h", rd_valid, rd_data_a, rd_data_b, e.a, e.b);
      end
      wr_sel = 16'h0040; wr_data = 32'h1234_5678;
      rd_addr_a = 4'd6; rd_addr_b = 4'd6;
      tick();
      e = pop_exp();
      checks++;
      if (rd_data_a !== e.a || rd_data_b !== e.b || rd_valid !== 1'b1) begin
         failures++;
         $display("FAIL bypass_both: got v=%b a=%h b=%h, expected v=1 a=%h b=%h", rd_valid, rd_data_a, rd_data_b, e.a, e.b);
      end
      wr_sel = 16'h0001; wr_data = 32'hFFFF_FFFF;
      rd_addr_a = 4'd0; rd_addr_b = 4'd5;
      tick();
      e = pop_exp();
      checks++;
      if (rd_data_a !== e.a || rd_data_b !== e.b || rd_valid !== 1'b1) begin
         failures++;
         $display("FAIL bypass_r0: got v=%b a=%h b=%h, expected v=1 a=%h b=%h", rd_valid, rd_data_a, rd_data_b, e.a, e.b);
      end
      idle();
      tick();
   endtask

   task automatic test_illegal();
      exp_t        e;
      logic [15:0] bad [3];
      bad[0] = 16'h0000; bad[1] = 16'h0030; bad[2] = 16'hxxxx;
      idle();
      wr_sel = 16'hFFFF; wr_data = 32'h0BAD_0BAD;
      tick();
      checks++;
      if (sel_error !== err_model) begin
         failures++;
         $display("FAIL ignore_sel_when_idle: got err=%b, expected %b", sel_error, err_model);
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         wr_en = 1'b1; wr_sel = bad[i]; wr_data = 32'hBAD0_0000 + 32'(i);
         rd_en = 1'b1; rd_addr_a = 4'd4; rd_addr_b = 4'd5;
         tick();
         e = pop_exp();
         checks++;
         if (sel_error !== err_model || rd_data_a !== e.a || rd_data_b !== e.b) begin
            failures++;
            $display("FAIL illegal_sel %0d: got err=%b a=%h b=%h, expected err=%b a=%h b=%h", i, sel_error, rd_data_a, rd_data_b, err_model, e.a, e.b);
         end
      end
      idle();
      wr_en = 1'b1; wr_sel = 16'h0008; wr_data = 32'h3333_3333;
      tick();
      checks++;
      if (sel_error !== err_model) begin
         failures++;
         $display("FAIL sticky_error: got %b, expected %b", sel_error, err_model);
      end
      for (int k = 0; k < 16; k++) begin
         idle();
         rd_en = 1'b1; rd_addr_a = 4'(k); rd_addr_b = 4'(15 - k);
         tick();
         e = pop_exp();
         checks++;
         if (rd_valid !== 1'b1 || rd_data_a !== e.a || rd_data_b !== e.b) begin
            failures++;
            $display("FAIL illegal_readback r%0d: got v=%b a=%h b=%h, expected v=1 a=%h b=%h", k, rd_valid, rd_data_a, rd_data_b, e.a, e.b);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      idle();
      rd_en = 1'b1; rd_addr_a = 4'd9; rd_addr_b = 4'd5;
      wr_en = 1'b1; wr_sel = 16'h0200; wr_data = 32'h9999_9999;
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if (rd_valid !== 1'b0 || rd_data_a !== 32'd0 || rd_data_b !== 32'd0 || sel_error !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got v=%b a=%h b=%h err=%b, expected all 0", rd_valid, rd_data_a, rd_data_b, sel_error);
      end
      wr_en = 1'b0; wr_sel = 16'h0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_after_reset: got %b, expected 0", rd_valid);
      end
      tick();
      e = pop_exp();
      checks++;
      if (rd_valid !== 1'b1 || rd_data_a !== e.a || rd_data_b !== e.b || sel_error !== err_model) begin
         failures++;
         $display("FAIL first_read_after_reset: got v=%b a=%h b=%h err=%b, expected v=1 a=%h b=%h err=%b", rd_valid, rd_data_a, rd_data_b, sel_error, e.a, e.b, err_model);
      end
      idle();
      tick();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      test_reset();
      test_write_sweep();
      test_bypass();
      test_illegal();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
